// File: rtl/mux_pkg.sv
// Shared select encoding for the 4:1 datapath mux.
// Callers drive sel with these names and the decode matches on them.
// No logic lives here, only types.
package mux_pkg;

  typedef enum logic [1:0] {
    SEL_D0 = 2'b00,
    SEL_D1 = 2'b01,
    SEL_D2 = 2'b10,
    SEL_D3 = 2'b11
  } mux_sel_t;

endpackage : mux_pkg

// File: rtl/mux_4to1_n_if.sv
// Bundle of the mux data/select inputs and both outputs.
// master drives data and select; slave (the mux) drives y and y_q.
// No handshake: the bundle carries plain data every cycle.
interface mux_4to1_n_if #(
  parameter int N = 4
);
  import mux_pkg::*;

  logic [N-1:0] d0;
  logic [N-1:0] d1;
  logic [N-1:0] d2;
  logic [N-1:0] d3;
  mux_sel_t     sel;
  logic [N-1:0] y;
  logic [N-1:0] y_q;

  modport master (
    output d0, d1, d2, d3, sel,
    input  y, y_q
  );

  modport slave (
    input  d0, d1, d2, d3, sel,
    output y, y_q
  );

endinterface : mux_4to1_n_if

// File: rtl/mux_4to1_n.sv
// N-bit 4:1 mux: y is combinational (zero latency), y_q registers y.
// y_q is exactly one cycle behind y; sync active-high rst clears y_q only.
// No backpressure: inputs are consumed every cycle.
module mux_4to1_n
  import mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_4to1_n_if.slave   bus
);

  // A zero-width mux has no meaning; stop elaboration rather than build one.
  generate
    if (N < 1) begin : g_bad_width
      $error("mux_4to1_n: N must be >= 1");
    end
  endgenerate

  logic [N-1:0] y_sel;

  // Decode the select code; the default arm is only reachable with X/Z on sel.
  always_comb begin
    y_sel = '0;
    case (bus.sel)
      SEL_D0:  y_sel = bus.d0;
      SEL_D1:  y_sel = bus.d1;
      SEL_D2:  y_sel = bus.d2;
      SEL_D3:  y_sel = bus.d3;
      default: y_sel = '0;
    endcase
  end

  assign bus.y = y_sel;

  // Registered copy of the selection; reset clears it without touching y.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_q <= '0;
    end else begin
      bus.y_q <= y_sel;
    end
  end

endmodule : mux_4to1_n

// File: tb/tb_mux_4to1_n.sv
// Directed bench for mux_4to1_n at N = 4, 32 and 1.
// Inputs change #1 after the rising edge; outputs are sampled there too.
// Ends with a one-line summary of comparisons and failures.
module tb_mux_4to1_n;
  import mux_pkg::*;

  logic clk;
  logic rst;

  int n_checks;
  int n_fails;

  mux_4to1_n_if #(.N(4))  bus4  ();
  mux_4to1_n_if #(.N(32)) bus32 ();
  mux_4to1_n_if #(.N(1))  bus1  ();

  mux_4to1_n #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  mux_4to1_n #(.N(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  mux_4to1_n #(.N(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  mux_sel_t sels [4];
  logic     bits1 [4];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    sels  = '{SEL_D0, SEL_D1, SEL_D2, SEL_D3};
    bits1 = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    bus4.d0 = '0;  bus4.d1 = '0;  bus4.d2 = '0;  bus4.d3 = '0;  bus4.sel = SEL_D0;
    bus32.d0 = '0; bus32.d1 = '0; bus32.d2 = '0; bus32.d3 = '0; bus32.sel = SEL_D0;
    bus1.d0 = '0;  bus1.d1 = '0;  bus1.d2 = '0;  bus1.d3 = '0;  bus1.sel = SEL_D0;
    #1;
    check("zero_y_comb", 32'(bus4.y), 32'h0);

    tick();
    check("reset_y_q", 32'(bus4.y_q), 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_y_q", 32'(bus4.y_q), 32'h0);

    // Walking-one select, no clock between selections.
    bus4.d0 = 4'b0001; bus4.d1 = 4'b0010; bus4.d2 = 4'b0100; bus4.d3 = 4'b1000;
    bus4.sel = SEL_D0; #1; check("walk_sel00", 32'(bus4.y), 32'h1);
    bus4.sel = SEL_D1; #1; check("walk_sel01", 32'(bus4.y), 32'h2);
    bus4.sel = SEL_D2; #1; check("walk_sel10", 32'(bus4.y), 32'h4);
    bus4.sel = SEL_D3; #1; check("walk_sel11", 32'(bus4.y), 32'h8);

    // One-cycle latency on y_q.
    bus4.sel = SEL_D0;
    tick();
    check("lat_prev", 32'(bus4.y_q), 32'h1);
    bus4.sel = SEL_D3; #1;
    check("lat_hold", 32'(bus4.y_q), 32'h1);
    check("lat_y_now", 32'(bus4.y), 32'h8);
    tick();
    check("lat_edge_k", 32'(bus4.y_q), 32'h8);

    // Synchronous reset clears y_q only.
    rst = 1'b1;
    tick();
    check("rst_y_q", 32'(bus4.y_q), 32'h0);
    check("rst_y_kept", 32'(bus4.y), 32'h8);
    rst = 1'b0;
    tick();
    check("rst_resume", 32'(bus4.y_q), 32'h8);

    // Data change under fixed select.
    bus4.sel = SEL_D2; #1;
    check("fix_y_0100", 32'(bus4.y), 32'h4);
    tick();
    check("fix_yq_0100", 32'(bus4.y_q), 32'h4);
    bus4.d2 = 4'b1111; #1;
    check("fix_y_1111", 32'(bus4.y), 32'hF);
    check("fix_yq_hold", 32'(bus4.y_q), 32'h4);
    tick();
    check("fix_yq_1111", 32'(bus4.y_q), 32'hF);
    bus4.d0 = 4'b1010; bus4.d1 = 4'b0101; bus4.d3 = 4'b0011; #1;
    check("fix_other_y", 32'(bus4.y), 32'hF);
    tick();
    check("fix_other_yq", 32'(bus4.y_q), 32'hF);

    // Select and data change together.
    bus4.sel = SEL_D1; bus4.d1 = 4'b0110; #1;
    check("both_y", 32'(bus4.y), 32'h6);
    tick();
    check("both_yq", 32'(bus4.y_q), 32'h6);

    // N = 32.
    bus32.d0 = 32'h0123_4567; bus32.d1 = 32'h89AB_CDEF;
    bus32.d2 = 32'hCAFE_F00D; bus32.d3 = 32'hDEAD_BEEF;
    bus32.sel = SEL_D3; #1;
    check("n32_sel11", bus32.y, 32'hDEAD_BEEF);
    tick();
    check("n32_yq", bus32.y_q, 32'hDEAD_BEEF);
    bus32.sel = SEL_D2; #1;
    check("n32_sel10", bus32.y, 32'hCAFE_F00D);

    // N = 1 walking select.
    bus1.d0 = bits1[0]; bus1.d1 = bits1[1]; bus1.d2 = bits1[2]; bus1.d3 = bits1[3];
    for (int i = 0; i < 4; i++) begin
      bus1.sel = sels[i]; #1;
      check($sformatf("n1_sel%0d", i), 32'(bus1.y), 32'(bits1[i]));
      tick();
      check($sformatf("n1_yq%0d", i), 32'(bus1.y_q), 32'(bits1[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_mux_4to1_n

// File: doc/mux_4to1_n.md
Name: mux_4to1_n

Overview:
- N-bit wide 4-to-1 multiplexer used in the processor datapath, e.g. ALU operand, writeback and PC-source selection.
- Two outputs:
  - y: combinational, zero latency; this is the primary datapath output.
  - y_q: a registered copy of y, for pipelined consumers.
- Single clock domain. Synchronous, active-high reset.

Parameters:
- N, 4: data width of d0..d3, y and y_q in bits. Legal range N >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- d0  input  N  data input, selected when sel = 2'b00.
- d1  input  N  data input, selected when sel = 2'b01.
- d2  input  N  data input, selected when sel = 2'b10.
- d3  input  N  data input, selected when sel = 2'b11.
- sel  input  2  select code.
- y  output  N  combinational selected data.
- y_q  output  N  registered selected data, one cycle behind y.

Behaviour:
- Combinational path (y):
  - sel = 00 -> y = d0; 01 -> d1; 10 -> d2; 11 -> d3.
  - Pure combinational logic, zero-cycle latency; y follows changes on d0..d3 and sel within the same delta/cycle.
  - y does not depend on clk or rst; rst never forces y.
  - Fully decoded, no inferred latches.
  - Default branch drives y = '0. This is reachable only with X/Z on sel in simulation.
  - Bit widths are preserved exactly; no extension or truncation inside the block.
- Registered path (y_q):
  - On rising clk with rst = 1: y_q <= '0.
  - On rising clk with rst = 0: y_q <= y, i.e. the value selected by d*/sel as sampled at that edge.
  - Latency is exactly 1 cycle from sel/data to y_q.
  - Reset value of y_q is all zeros.
  - Before the first clock edge y_q is X; no initial-block initialisation is permitted.
  - If rst is asserted mid-stream, y_q clears on that edge. It resumes tracking y on the first edge with rst = 0, and then shows the selection sampled at that edge.
- Boundary conditions:
  - sel and data changing in the same cycle: y_q captures the new combined selection at the next edge.
  - N = 1: the block degenerates to a 1-bit 4:1 mux and must still elaborate cleanly.
  - Out-of-range sel is impossible: 2 bits cover all 4 codes.
- No handshake and no state machine.

Decomposition:
- Shared package mux_pkg, containing:
  - typedef enum logic [1:0] mux_sel_t with SEL_D0 = 2'b00, SEL_D1 = 2'b01, SEL_D2 = 2'b10, SEL_D3 = 2'b11.
  - Callers use these names when driving sel; the decode uses them in its case items.
- Single module, no sub-module.
  - Combinational decode goes in one always_comb.
  - Output register goes in one always_ff.
- Generate-time assertion that N >= 1.

Test Plan:
- All inputs 0, sel = 00 -> y = 4'b0000.
- After several cycles with rst = 0, y_q = 4'b0000.
- Walking-one select, with d0 = 4'b0001, d1 = 4'b0010, d2 = 4'b0100, d3 = 4'b1000:
  - sel = 00 -> y = 0001.
  - sel = 01 -> y = 0010.
  - sel = 10 -> y = 0100.
  - sel = 11 -> y = 1000.
  - Each result appears immediately, with no clock required.
- Registered latency: same data, rst = 0, sel changes 00 -> 11 just before edge k -> y_q = 1000 after edge k.
  - y_q holds the previous value (0001) until edge k.
- Sync reset: y_q = 1000, assert rst for one edge -> y_q = 0000 at that edge while y stays 1000.
  - Deassert rst -> y_q = 1000 on the next edge.
- Data change under fixed select: sel = 10, d2 changes 0100 -> 1111 -> y = 1111 immediately and y_q = 1111 after the next edge.
  - Changes on d0/d1/d3 do not affect y.
- Width sweep: rebuild with N = 1 and N = 32.
  - N = 32: d3 = 32'hDEAD_BEEF, sel = 11 -> y = 32'hDEAD_BEEF.
  - N = 1: walking-select pattern with d0..d3 = 1, 0, 1, 0 -> y = 1, 0, 1, 0 for sel = 00..11.
